// File: rtl/alarm_annunciator.sv
// rtl/alarm_annunciator.sv - alarm ring/snooze/dismiss sequencer driving LED and buzzer
module alarm_annunciator #(
    parameter  int SNOOZE_TICKS = 600,
    parameter  int RING_TIMEOUT = 120,
    parameter  int MAX_SNOOZE   = 3,
    localparam int W            = $clog2(MAX_SNOOZE + 1)
) (
    input  logic         clk2hz,
    input  logic         reset,
    input  logic         armado,
    input  logic         alarmaDisparo,
    input  logic         botonPosponer,
    input  logic         botonDetener,
    output logic         mostrarLed,
    output logic         zumbador,
    output logic         sonando,
    output logic         pospuesto,
    output logic [W-1:0] conteoPospuestos
);

    localparam int RW = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
    localparam int SW = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    // Synchronizers and previous-value registers for the three async inputs
    logic       trig_s1_q, trig_s2_q, trig_prev_q;
    logic [2:0] trig_vld_q;
    logic       pos_s1_q, pos_s2_q, pos_prev_q;
    logic       det_s1_q, det_s2_q, det_prev_q;

    logic trig_edge, press_pos, press_det;

    state_t        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic [1:0]    pat_q, pat_d, pat_inc;
    logic          led_q, led_d;
    logic          buz_q, buz_d;
    logic          son_q, son_d;
    logic          pos_q, pos_d;
    logic [W-1:0]  cnt_q, cnt_d;

    logic snooze_ok, ring_done, snz_done;
    logic enter_idle, enter_ring, enter_snz;

    // Two-flop synchronizers plus edge history; idle levels on reset
    always_ff @(posedge clk2hz or negedge reset) begin
        if (!reset) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            trig_vld_q  <= 3'b000;
            pos_s1_q    <= 1'b1;
            pos_s2_q    <= 1'b1;
            pos_prev_q  <= 1'b1;
            det_s1_q    <= 1'b1;
            det_s2_q    <= 1'b1;
            det_prev_q  <= 1'b1;
        end else begin
            trig_s1_q   <= alarmaDisparo;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
            trig_vld_q  <= {trig_vld_q[1:0], 1'b1};
            pos_s1_q    <= botonPosponer;
            pos_s2_q    <= pos_s1_q;
            pos_prev_q  <= pos_s2_q;
            det_s1_q    <= botonDetener;
            det_s2_q    <= det_s1_q;
            det_prev_q  <= det_s2_q;
        end
    end

    // The trigger chain resets to 0, so a level already high at reset release would
    // look like a rising edge; edges only count once the history holds a real sample.
    assign trig_edge = trig_vld_q[2] & trig_s2_q & ~trig_prev_q;
    assign press_pos = pos_prev_q & ~pos_s2_q;
    assign press_det = det_prev_q & ~det_s2_q;

    // Next-state, counters and registered output values
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        pat_d      = pat_q;
        led_d      = led_q;
        buz_d      = buz_q;
        cnt_d      = cnt_q;
        enter_idle = 1'b0;
        enter_ring = 1'b0;
        enter_snz  = 1'b0;
        pat_inc    = pat_q + 2'd1;
        snooze_ok  = (cnt_q < W'(MAX_SNOOZE));
        ring_done  = (ring_cnt_q == RW'(RING_TIMEOUT - 1));
        snz_done   = (snz_cnt_q == SW'(SNOOZE_TICKS - 1));

        if (!armado) begin
            enter_idle = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig_edge) begin
                        enter_ring = 1'b1;
                        cnt_d      = '0;
                    end
                end
                RINGING: begin
                    if (press_det) begin
                        enter_idle = 1'b1;
                    end else if (press_pos && snooze_ok) begin
                        enter_snz = 1'b1;
                    end else if (ring_done) begin
                        if (snooze_ok) begin
                            enter_snz = 1'b1;
                        end else begin
                            enter_idle = 1'b1;
                        end
                    end else begin
                        ring_cnt_d = ring_cnt_q + RW'(1);
                        pat_d      = pat_inc;
                        led_d      = ~led_q;
                        buz_d      = ~pat_inc[1];
                    end
                end
                SNOOZE: begin
                    if (press_det) begin
                        enter_idle = 1'b1;
                    end else if (snz_done) begin
                        enter_ring = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q + SW'(1);
                    end
                end
                default: enter_idle = 1'b1;
            endcase
        end

        if (enter_idle) begin
            state_d = IDLE;
            led_d   = 1'b0;
            buz_d   = 1'b0;
        end else if (enter_ring) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            pat_d      = 2'd0;
            led_d      = 1'b1;
            buz_d      = 1'b1;
        end else if (enter_snz) begin
            state_d   = SNOOZE;
            snz_cnt_d = '0;
            cnt_d     = cnt_q + W'(1);
            led_d     = 1'b1;
            buz_d     = 1'b0;
        end

        son_d = (state_d == RINGING);
        pos_d = (state_d == SNOOZE);
    end

    // State, counter and output registers
    always_ff @(posedge clk2hz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            pat_q      <= 2'd0;
            led_q      <= 1'b0;
            buz_q      <= 1'b0;
            son_q      <= 1'b0;
            pos_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            pat_q      <= pat_d;
            led_q      <= led_d;
            buz_q      <= buz_d;
            son_q      <= son_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mostrarLed       = led_q;
    assign zumbador         = buz_q;
    assign sonando          = son_q;
    assign pospuesto        = pos_q;
    assign conteoPospuestos = cnt_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb/tb_alarm_annunciator.sv - randomized model-checked bench for alarm_annunciator
module tb_alarm_annunciator;

    localparam int ST = 8;
    localparam int RT = 6;
    localparam int MS = 3;
    localparam int W  = 2;
    localparam int NH = 4096;

    logic         clk2hz        = 1'b0;
    logic         reset         = 1'b0;
    logic         armado        = 1'b0;
    logic         alarmaDisparo = 1'b0;
    logic         botonPosponer = 1'b1;
    logic         botonDetener  = 1'b1;
    logic         mostrarLed;
    logic         zumbador;
    logic         sonando;
    logic         pospuesto;
    logic [W-1:0] conteoPospuestos;

    alarm_annunciator #(
        .SNOOZE_TICKS (ST),
        .RING_TIMEOUT (RT),
        .MAX_SNOOZE   (MS)
    ) dut (
        .clk2hz           (clk2hz),
        .reset            (reset),
        .armado           (armado),
        .alarmaDisparo    (alarmaDisparo),
        .botonPosponer    (botonPosponer),
        .botonDetener     (botonDetener),
        .mostrarLed       (mostrarLed),
        .zumbador         (zumbador),
        .sonando          (sonando),
        .pospuesto        (pospuesto),
        .conteoPospuestos (conteoPospuestos)
    );

    always #5 clk2hz = ~clk2hz;

    int total = 0;
    int bad   = 0;

    // pin values seen at each rising edge
    bit tr_h  [NH];
    bit pos_h [NH];
    bit det_h [NH];
    bit arm_h [NH];
    int edge_n = 0;
    int rmark  = 0;   // last edge index whose samples were wiped by reset

    // reference model: mode 0 idle, 1 ringing, 2 snoozed; times kept as edge indices
    int m_mode  = 0;
    int m_enter = 0;
    int m_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit p_tr(int j);
        return (j <= rmark) ? 1'b0 : tr_h[j];
    endfunction

    function automatic bit p_pos(int j);
        return (j <= rmark) ? 1'b1 : pos_h[j];
    endfunction

    function automatic bit p_det(int j);
        return (j <= rmark) ? 1'b1 : det_h[j];
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_count = 0;
    endtask

    task automatic model_step(input int k);
        bit te, pp, pd;
        int el;
        te = (k - 3 > rmark) && p_tr(k - 2) && !p_tr(k - 3);
        pp = p_pos(k - 3) && !p_pos(k - 2);
        pd = p_det(k - 3) && !p_det(k - 2);
        el = k - m_enter;
        if (!arm_h[k]) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (te) begin
                m_mode  = 1;
                m_enter = k;
                m_count = 0;
            end
        end else if (m_mode == 1) begin
            if (pd) begin
                m_mode = 0;
            end else if ((pp || el == RT) && m_count < MS) begin
                m_mode  = 2;
                m_enter = k;
                m_count = m_count + 1;
            end else if (el == RT) begin
                m_mode = 0;
            end
        end else begin
            if (pd) begin
                m_mode = 0;
            end else if (el == ST) begin
                m_mode  = 1;
                m_enter = k;
            end
        end
    endtask

    task automatic compare_all();
        int  el;
        bit  e_led, e_buz;
        el    = edge_n - m_enter;
        e_led = (m_mode == 2) || (m_mode == 1 && (el % 2) == 0);
        e_buz = (m_mode == 1) && ((el % 4) < 2);
        check("sonando",   sonando,          (m_mode == 1));
        check("pospuesto", pospuesto,        (m_mode == 2));
        check("led",       mostrarLed,       e_led);
        check("buzzer",    zumbador,         e_buz);
        check("snz_count", conteoPospuestos, m_count);
    endtask

    task automatic tick();
        @(posedge clk2hz);
        edge_n++;
        tr_h[edge_n]  = alarmaDisparo;
        pos_h[edge_n] = botonPosponer;
        det_h[edge_n] = botonDetener;
        arm_h[edge_n] = armado;
        if (!reset) begin
            rmark = edge_n;
            model_reset();
        end else begin
            model_step(edge_n);
        end
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // assert reset between edges and check the outputs clear at once
    task automatic reset_now();
        reset = 1'b0;
        rmark = edge_n;
        model_reset();
        #1;
        check("rst_led",   mostrarLed,       0);
        check("rst_buz",   zumbador,         0);
        check("rst_son",   sonando,          0);
        check("rst_pos",   pospuesto,        0);
        check("rst_count", conteoPospuestos, 0);
    endtask

    int hold_pos = 0;
    int hold_det = 0;
    int arm_off  = 0;

    initial begin
        // reset held for a few edges, released between edges
        run(3);
        reset  = 1'b1;
        armado = 1'b1;
        run(2);
        // trigger rise: ringing appears on the third edge
        alarmaDisparo = 1'b1;
        run(2);
        check("ring_early", sonando, 0);
        run(1);
        check("ring_3rd", sonando, 1);
        run(3);
        // snooze press held two edges, then the snooze period expires
        botonPosponer = 1'b0;
        run(2);
        botonPosponer = 1'b1;
        run(2);
        check("snoozed", pospuesto, 1);
        check("snz_one", conteoPospuestos, 1);
        run(ST + 2);
        // both buttons together: dismiss wins
        botonPosponer = 1'b0;
        botonDetener  = 1'b0;
        run(3);
        botonPosponer = 1'b1;
        botonDetener  = 1'b1;
        check("both_idle", sonando, 0);
        run(2);
        // new event, then reset mid-ringing with the trigger held high
        alarmaDisparo = 1'b0;
        run(2);
        alarmaDisparo = 1'b1;
        run(5);
        reset_now();
        run(2);
        reset = 1'b1;
        run(10);
        check("no_rering", sonando, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) alarmaDisparo = ~alarmaDisparo;
            if (hold_pos > 0) begin
                hold_pos--;
                if (hold_pos == 0) botonPosponer = 1'b1;
            end else if ($urandom_range(0, 5) == 0) begin
                botonPosponer = 1'b0;
                hold_pos      = $urandom_range(1, 4);
            end
            if (hold_det > 0) begin
                hold_det--;
                if (hold_det == 0) botonDetener = 1'b1;
            end else if ($urandom_range(0, 44) == 0) begin
                botonDetener = 1'b0;
                hold_det     = $urandom_range(1, 3);
            end
            if (arm_off > 0) begin
                arm_off--;
                if (arm_off == 0) armado = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                armado  = 1'b0;
                arm_off = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 699) == 0) begin
                reset_now();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
